// File: rtl/uart_rx_monitor.sv
// UART receive monitor: 2-FF synchroniser, frame decoder, FWFT byte FIFO,
// sticky framing/overflow flags and an inactivity timeout.
module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          rxd_i,
  input  logic                          rd_en_i,
  output logic [DATA_BITS-1:0]          rd_data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          byte_valid_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic                          timeout_o
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0]   BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BAUD_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);
  localparam logic [TW-1:0]   T_MAX     = TW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 good_stop;
  logic                 push_ok;
  logic                 pop;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [TW-1:0]        tcnt;

  // Two-stage synchroniser for the asynchronous serial line, idle-high on reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd_i;
      rx_s    <= rx_meta;
    end
  end

  assign good_stop = rstn_i && (state == S_STOP) && (baud_cnt == BAUD_FULL) && rx_s;

  // Frame decoder: mid-bit sampling from the start-bit centre, LSB first
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (baud_cnt == BAUD_HALF) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_FULL) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) state <= S_STOP;
            else bit_cnt <= bit_cnt + BW'(1);
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_cnt == BAUD_FULL) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          baud_cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-cycle pulse following every good stop bit, whether or not the byte fit
  always_ff @(posedge clk_i) begin
    if (!rstn_i) byte_valid_o <= 1'b0;
    else         byte_valid_o <= good_stop;
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign push_ok   = good_stop && (!full_o || rd_en_i);
  assign pop       = rd_en_i && !empty_o;
  assign empty_o   = (count_o == '0);
  assign full_o    = (count_o == CNT_FULL);
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr];

  // FIFO storage (no reset needed; head is masked to zero while empty)
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_o <= count_o + CNTW'(1);
        2'b01:   count_o <= count_o - CNTW'(1);
        default: count_o <= count_o;
      endcase
      if (good_stop && !push_ok) overflow_o <= 1'b1;
    end
  end

  // Saturating inactivity counter, cleared by any good stop bit
  always_ff @(posedge clk_i) begin
    if (!rstn_i)             tcnt <= '0;
    else if (good_stop)      tcnt <= '0;
    else if (tcnt != T_MAX)  tcnt <= tcnt + TW'(1);
  end

  assign timeout_o = (tcnt == T_MAX);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at 16 clk/bit, 8 data bits, 16-deep FIFO.
module tb_uart_rx_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rxd;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       byte_valid;
  logic       frame_err;
  logic       overflow;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int p0;

  uart_rx_monitor #(
    .CLKS_PER_BIT  (16),
    .DATA_BITS     (8),
    .FIFO_DEPTH    (16),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .rxd_i       (rxd),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .empty_o     (empty),
    .full_o      (full),
    .count_o     (count),
    .byte_valid_o(byte_valid),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // Count byte_valid pulses, sampled on the inactive edge
  always @(negedge clk) if (byte_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge ending the stop bit.
  // With pop_on_push, rd_en is high only for the edge that samples the stop bit.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic pop_on_push);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop_bit;
    for (int j = 0; j < 16; j++) begin
      rd_en = (pop_on_push && j == 10);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rxd  = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn  = 1'b0;
    rxd   = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset state
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_data", rd_data, 8'h00);
    check("rst_valid", byte_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tmo", timeout, 0);

    // 1: two good frames
    p0 = pulses;
    send_byte(8'h55, 1'b1, 1'b0);
    idle(4);
    send_byte(8'hA3, 1'b1, 1'b0);
    idle(4);
    check("t1_pulses", pulses, p0 + 2);
    check("t1_count", count, 2);
    pop_check("t1_pop0", 8'h55);
    pop_check("t1_pop1", 8'hA3);
    @(negedge clk);
    check("t1_empty", empty, 1);

    // 2: short low glitch is rejected
    p0 = pulses;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("t2_pulses", pulses, p0);
    check("t2_count", count, 0);
    check("t2_ferr", frame_err, 0);

    // 3: framing error, then a good frame
    p0 = pulses;
    send_byte(8'h3C, 1'b0, 1'b0);
    idle(4);
    check("t3_ferr", frame_err, 1);
    check("t3_count", count, 0);
    check("t3_pulses", pulses, p0);
    send_byte(8'h12, 1'b1, 1'b0);
    idle(4);
    check("t3_count2", count, 1);
    check("t3_pulses2", pulses, p0 + 1);
    pop_check("t3_pop", 8'h12);

    // 4: overflow on the 17th byte
    for (int b = 0; b < 16; b++) begin
      send_byte(8'(b), 1'b1, 1'b0);
      idle(2);
    end
    check("t4_full", full, 1);
    check("t4_count16", count, 16);
    check("t4_ovf0", overflow, 0);
    p0 = pulses;
    send_byte(8'h10, 1'b1, 1'b0);
    idle(2);
    check("t4_ovf1", overflow, 1);
    check("t4_count_sat", count, 16);
    check("t4_pulse_drop", pulses, p0 + 1);
    for (int b = 0; b < 16; b++) pop_check("t4_pop", 8'(b));
    @(negedge clk);
    check("t4_empty", empty, 1);

    // 5: push and pop together while full
    do_reset();
    for (int b = 0; b < 16; b++) begin
      send_byte(8'(8'h20 + b), 1'b1, 1'b0);
      idle(2);
    end
    check("t5_full", full, 1);
    send_byte(8'h77, 1'b1, 1'b1);
    idle(2);
    check("t5_count", count, 16);
    check("t5_ovf", overflow, 0);
    for (int b = 1; b < 16; b++) pop_check("t5_pop", 8'(8'h20 + b));
    pop_check("t5_pop_last", 8'h77);
    @(negedge clk);
    check("t5_empty", empty, 1);

    // 6: reset mid-frame, then timeout after exactly 2000 cycles
    p0 = pulses;
    @(negedge clk);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rstn = 1'b0;
    rxd  = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (1999) @(posedge clk);
    #1;
    check("t6_empty", empty, 1);
    check("t6_count", count, 0);
    check("t6_nopulse", pulses, p0);
    check("t6_tmo_1999", timeout, 0);
    @(posedge clk);
    #1;
    check("t6_tmo_2000", timeout, 1);
    @(negedge clk);
    send_byte(8'h5A, 1'b1, 1'b0);
    idle(2);
    check("t6_tmo_clr", timeout, 0);
    pop_check("t6_pop", 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
